uart_io_top: RTL and testbench

- Board-level I/O controller driven over a UART link: a host sends command bytes to set the 4 LEDs, read the buttons/switches, and arm button interrupts.
- Armed button presses are reported to the host as asynchronous event bytes.
- Sits at the FPGA top level and connects directly to board pins; no CPU is involved.

---
 rtl/uart_io_top.sv | 343 ++++++++++++++++++++++++++++++++++
 tb/tb_uart_io_top.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_io_top.sv
// uart_io_top: board-level I/O controller driven over a UART link.
// A host sends single-byte commands:
//   'L' <b>  sets the LEDs to b[3:0].
//   'I' <b>  sets the button interrupt mask to b[3:0].
//   'S'      reads the inputs back as {buttons, switches}.
// Any other byte in the idle state is answered with NAK (0x15).
// Rising edges on armed buttons are reported as event bytes 0x80 | pending.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   buttom   push buttons (asynchronous, active high)
//   switch   slide switches (asynchronous)
//   led      LED drive (registered)
//   uart_rx  UART receive line (asynchronous, idle high)
//   uart_tx  UART transmit line (registered, idle high)
module uart_io_top #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] buttom,
  input  logic [3:0] switch,
  output logic [3:0] led,
  input  logic       uart_rx,
  output logic       uart_tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3} tx_state_t;
  typedef enum logic [1:0] {DEC_IDLE = 2'd0, DEC_WAIT_LED = 2'd1, DEC_WAIT_MASK = 2'd2} dec_state_t;

  // synchronisers
  logic [3:0] btn_meta_r, btn_sync_r, btn_prev_r;
  logic [3:0] sw_meta_r, sw_sync_r;
  logic       rx_meta_r, rx_sync_r, rx_prev_r;

  // receiver
  rx_state_t        rx_state_r, rx_state_s;
  logic [CNT_W-1:0] rx_cnt_r, rx_cnt_s;
  logic [2:0]       rx_idx_r, rx_idx_s;
  logic [7:0]       rx_shift_r, rx_shift_s;
  logic             rx_valid_s;

  // decoder
  dec_state_t dec_state_r, dec_state_s;
  logic [3:0] led_r, led_s;
  logic [3:0] irq_mask_r, irq_mask_s;
  logic       reply_gen_s;
  logic [7:0] reply_byte_s;

  // reply slot, interrupts, arbitration
  logic       reply_full_r;
  logic [7:0] reply_data_r;
  logic [3:0] pending_r, pending_s, rise_s;
  logic       tx_ready_s, take_reply_s, take_event_s, tx_load_s;
  logic [7:0] tx_load_byte_s;

  // transmitter
  tx_state_t        tx_state_r, tx_state_s;
  logic [CNT_W-1:0] tx_cnt_r, tx_cnt_s;
  logic [2:0]       tx_idx_r, tx_idx_s;
  logic [7:0]       tx_shift_r, tx_shift_s;
  logic             tx_r, tx_s;

  assign led     = led_r;
  assign uart_tx = tx_r;

  // Two-flop synchronisers plus one history stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta_r <= 4'h0;
      btn_sync_r <= 4'h0;
      btn_prev_r <= 4'h0;
      sw_meta_r  <= 4'h0;
      sw_sync_r  <= 4'h0;
      rx_meta_r  <= 1'b1;
      rx_sync_r  <= 1'b1;
      rx_prev_r  <= 1'b1;
    end else begin
      btn_meta_r <= buttom;
      btn_sync_r <= btn_meta_r;
      btn_prev_r <= btn_sync_r;
      sw_meta_r  <= switch;
      sw_sync_r  <= sw_meta_r;
      rx_meta_r  <= uart_rx;
      rx_sync_r  <= rx_meta_r;
      rx_prev_r  <= rx_sync_r;
    end
  end

  // Receiver next-state: start check at mid-bit, then one sample per bit period
  always_comb begin
    rx_state_s = rx_state_r;
    rx_cnt_s   = rx_cnt_r;
    rx_idx_s   = rx_idx_r;
    rx_shift_s = rx_shift_r;
    rx_valid_s = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        rx_cnt_s = CNT_ZERO;
        if (rx_prev_r && !rx_sync_r) begin
          rx_state_s = RX_START;
        end else begin
          rx_state_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_r == HALF_LAST) begin
          rx_cnt_s = CNT_ZERO;
          rx_idx_s = 3'd0;
          // a line that is high again at mid-start was only a glitch
          if (rx_sync_r) begin
            rx_state_s = RX_IDLE;
          end else begin
            rx_state_s = RX_DATA;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == BIT_LAST) begin
          rx_cnt_s   = CNT_ZERO;
          rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
          if (rx_idx_r == 3'd7) begin
            rx_state_s = RX_STOP;
          end else begin
            rx_idx_s = rx_idx_r + 3'd1;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_r == BIT_LAST) begin
          rx_cnt_s   = CNT_ZERO;
          rx_valid_s = rx_sync_r;   // a low stop bit discards the byte
          rx_state_s = RX_IDLE;
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_ONE;
        end
      end
      default: begin
        rx_state_s = RX_IDLE;
        rx_cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Command decoder: state transitions, LED/mask updates and reply generation
  always_comb begin
    dec_state_s  = dec_state_r;
    led_s        = led_r;
    irq_mask_s   = irq_mask_r;
    reply_gen_s  = 1'b0;
    reply_byte_s = 8'h00;
    case (dec_state_r)
      DEC_IDLE: begin
        if (rx_valid_s) begin
          case (rx_shift_r)
            8'h4C: dec_state_s = DEC_WAIT_LED;
            8'h49: dec_state_s = DEC_WAIT_MASK;
            8'h53: begin
              reply_gen_s  = 1'b1;
              reply_byte_s = {btn_sync_r, sw_sync_r};
            end
            default: begin
              reply_gen_s  = 1'b1;
              reply_byte_s = 8'h15;
            end
          endcase
        end else begin
          dec_state_s = DEC_IDLE;
        end
      end
      DEC_WAIT_LED: begin
        if (rx_valid_s) begin
          led_s        = rx_shift_r[3:0];
          reply_gen_s  = 1'b1;
          reply_byte_s = 8'h4B;
          dec_state_s  = DEC_IDLE;
        end else begin
          dec_state_s = DEC_WAIT_LED;
        end
      end
      DEC_WAIT_MASK: begin
        if (rx_valid_s) begin
          irq_mask_s   = rx_shift_r[3:0];
          reply_gen_s  = 1'b1;
          reply_byte_s = 8'h4B;
          dec_state_s  = DEC_IDLE;
        end else begin
          dec_state_s = DEC_WAIT_MASK;
        end
      end
      default: dec_state_s = DEC_IDLE;
    endcase
  end

  // TX arbitration and pending update; the stop bit's last cycle also counts
  // as idle so that frames can run back to back
  always_comb begin
    tx_ready_s     = (tx_state_r == TX_IDLE) || ((tx_state_r == TX_STOP) && (tx_cnt_r == BIT_LAST));
    take_reply_s   = tx_ready_s && reply_full_r;
    take_event_s   = tx_ready_s && !reply_full_r && (pending_r != 4'h0);
    tx_load_s      = take_reply_s || take_event_s;
    if (take_reply_s) begin
      tx_load_byte_s = reply_data_r;
    end else begin
      tx_load_byte_s = {4'h8, pending_r};
    end
    rise_s = btn_sync_r & ~btn_prev_r & irq_mask_r;
    // new edges are OR-ed in after the clear so they are never lost
    if (take_event_s) begin
      pending_s = rise_s;
    end else begin
      pending_s = pending_r | rise_s;
    end
  end

  // Transmitter next-state: each bit held for one full bit period
  always_comb begin
    tx_state_s = tx_state_r;
    tx_cnt_s   = tx_cnt_r;
    tx_idx_s   = tx_idx_r;
    tx_shift_s = tx_shift_r;
    tx_s       = tx_r;
    case (tx_state_r)
      TX_IDLE: begin
        tx_cnt_s = CNT_ZERO;
        if (tx_load_s) begin
          tx_state_s = TX_START;
          tx_shift_s = tx_load_byte_s;
          tx_s       = 1'b0;
        end else begin
          tx_state_s = TX_IDLE;
          tx_s       = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_cnt_s   = CNT_ZERO;
          tx_idx_s   = 3'd0;
          tx_s       = tx_shift_r[0];
          tx_state_s = TX_DATA;
        end else begin
          tx_cnt_s = tx_cnt_r + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_cnt_s = CNT_ZERO;
          if (tx_idx_r == 3'd7) begin
            tx_state_s = TX_STOP;
            tx_s       = 1'b1;
          end else begin
            tx_idx_s   = tx_idx_r + 3'd1;
            tx_shift_s = {1'b1, tx_shift_r[7:1]};
            tx_s       = tx_shift_r[1];
          end
        end else begin
          tx_cnt_s = tx_cnt_r + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_cnt_s = CNT_ZERO;
          if (tx_load_s) begin
            tx_state_s = TX_START;
            tx_shift_s = tx_load_byte_s;
            tx_s       = 1'b0;
          end else begin
            tx_state_s = TX_IDLE;
            tx_s       = 1'b1;
          end
        end else begin
          tx_cnt_s = tx_cnt_r + CNT_ONE;
        end
      end
      default: begin
        tx_state_s = TX_IDLE;
        tx_cnt_s   = CNT_ZERO;
        tx_s       = 1'b1;
      end
    endcase
  end

  // State and datapath registers for RX, decoder, TX and interrupt logic
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_r  <= RX_IDLE;
      rx_cnt_r    <= CNT_ZERO;
      rx_idx_r    <= 3'd0;
      rx_shift_r  <= 8'h00;
      dec_state_r <= DEC_IDLE;
      led_r       <= 4'h0;
      irq_mask_r  <= 4'h0;
      pending_r   <= 4'h0;
      tx_state_r  <= TX_IDLE;
      tx_cnt_r    <= CNT_ZERO;
      tx_idx_r    <= 3'd0;
      tx_shift_r  <= 8'h00;
      tx_r        <= 1'b1;
    end else begin
      rx_state_r  <= rx_state_s;
      rx_cnt_r    <= rx_cnt_s;
      rx_idx_r    <= rx_idx_s;
      rx_shift_r  <= rx_shift_s;
      dec_state_r <= dec_state_s;
      led_r       <= led_s;
      irq_mask_r  <= irq_mask_s;
      pending_r   <= pending_s;
      tx_state_r  <= tx_state_s;
      tx_cnt_r    <= tx_cnt_s;
      tx_idx_r    <= tx_idx_s;
      tx_shift_r  <= tx_shift_s;
      tx_r        <= tx_s;
    end
  end

  // One-byte reply slot; a reply arriving while it is full is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      reply_full_r <= 1'b0;
      reply_data_r <= 8'h00;
    end else if (take_reply_s) begin
      reply_full_r <= 1'b0;
    end else if (reply_gen_s && !reply_full_r) begin
      reply_full_r <= 1'b1;
      reply_data_r <= reply_byte_s;
    end else begin
      reply_full_r <= reply_full_r;
    end
  end

endmodule

// File: tb/tb_uart_io_top.sv
// Directed testbench for uart_io_top: drives UART command frames, decodes the
// TX line into a byte queue and compares against hand-computed values.
module tb_uart_io_top;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] buttom, switch, led;
  logic       uart_rx, uart_tx;

  int         checks = 0;
  int         errors = 0;
  int         stop_errs = 0;
  logic [7:0] rx_q[$];
  logic [7:0] mon_b;
  logic       rst_seen = 1'b0;

  uart_io_top #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst     (rst),
    .buttom  (buttom),
    .switch  (switch),
    .led     (led),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  // Sticky flag so a frame cut short by reset is not logged as a byte
  always @(posedge clk) if (rst) rst_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Decode frames on uart_tx, sampling each bit near its middle
  initial begin : tx_monitor
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        rst_seen = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        if (uart_tx === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            mon_b[i] = uart_tx;
          end
          repeat (CPB) @(negedge clk);
          if (!rst_seen) begin
            if (uart_tx !== 1'b1) stop_errs++;
            else rx_q.push_back(mon_b);
          end
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    int waited = 0;
    while (rx_q.size() == 0 && waited < 3 * FRAME) begin
      @(negedge clk);
      waited++;
    end
    if (rx_q.size() == 0) check({tag, " timeout"}, 32'h1, 32'h0);
    else check(tag, 32'(rx_q.pop_front()), 32'(exp));
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int lows = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check({tag, " low cycles"}, 32'(lows), 32'h0);
    check({tag, " bytes"}, 32'(rx_q.size()), 32'h0);
  endtask

  initial begin : stimulus
    int w;
    buttom  = 4'h1;
    switch  = 4'h0;
    uart_rx = 1'b1;
    rst     = 1'b1;
    repeat (5) @(negedge clk);
    check("reset led", 32'(led), 32'h0);
    check("reset tx", 32'(uart_tx), 32'h1);
    rst = 1'b0;
    expect_quiet("idle after reset", 10 * FRAME);

    // LED write
    send_frame(8'h4C, 1'b1);
    send_frame(8'hA5, 1'b1);
    check("led write", 32'(led), 32'h5);
    expect_byte("led ack", 8'h4B);

    // status read: {buttons, switches}
    switch = 4'h2;
    repeat (4) @(negedge clk);
    send_frame(8'h53, 1'b1);
    expect_byte("status", 8'h12);

    // arm buttons 0 and 1 only
    send_frame(8'h49, 1'b1);
    send_frame(8'h03, 1'b1);
    expect_byte("mask ack", 8'h4B);
    buttom = 4'h3;
    expect_byte("event btn1", 8'h82);
    buttom = 4'h7;
    expect_quiet("masked edge", 3 * FRAME);

    // unknown command and framing error
    send_frame(8'h7A, 1'b1);
    expect_byte("nak", 8'h15);
    send_frame(8'h53, 1'b0);
    expect_quiet("framing error", 3 * FRAME);
    check("led after bad frame", 32'(led), 32'h5);

    // arm all, edges during a reply coalesce into one event
    send_frame(8'h49, 1'b1);
    send_frame(8'h0F, 1'b1);
    expect_byte("mask all ack", 8'h4B);
    buttom = 4'h0;
    repeat (4) @(negedge clk);
    send_frame(8'h53, 1'b1);
    buttom = 4'h1;
    repeat (2) @(negedge clk);
    buttom = 4'h9;
    expect_byte("reply before event", 8'h02);
    expect_byte("merged event", 8'h89);
    expect_quiet("single event", 2 * FRAME);

    // reset in the middle of a transmitted frame
    send_frame(8'h7A, 1'b1);
    w = 0;
    while (uart_tx !== 1'b0 && w < 3 * FRAME) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    check("tx low before reset", 32'(uart_tx), 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid-frame reset tx", 32'(uart_tx), 32'h1);
    check("mid-frame reset led", 32'(led), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    expect_quiet("after mid-frame reset", 3 * FRAME);
    check("tx stop bits", 32'(stop_errs), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
